// File: rtl/mips_exec_core.sv
// Execute-stage core: opcode decoder, two-result ALU with operand muxes,
// and a synchronous-write / combinational-read data memory.
module mips_exec_core #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluCtrl,
  output logic        memRd,
  output logic        memWr,
  output logic [1:0]  hiSel,
  output logic [1:0]  loSel,
  output logic        hiWr,
  output logic        loWr,
  output logic        maluOp,
  output logic        regDst,
  output logic        regWr,
  output logic        jump,
  output logic        branch,
  output logic        jalr,
  output logic [2:0]  memtoReg,
  output logic [31:0] resultA,
  output logic [31:0] resultB,
  output logic        zeroFlag,
  output logic [31:0] memReadData
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_SLL  = 6'b000110;
  localparam logic [5:0] OP_SRL  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001010;
  localparam logic [5:0] OP_SLTI = 6'b001011;
  localparam logic [5:0] OP_LUI  = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b010001;
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_MADD = 6'b011001;
  localparam logic [5:0] OP_MSUB = 6'b011010;
  localparam logic [5:0] OP_MFHI = 6'b011011;
  localparam logic [5:0] OP_MFLO = 6'b011100;
  localparam logic [5:0] OP_MTHI = 6'b011101;
  localparam logic [5:0] OP_MTLO = 6'b011110;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b100001;
  localparam logic [5:0] OP_JAL  = 6'b100010;
  localparam logic [5:0] OP_JALR = 6'b100011;

  // Control decode; everything is held at 0 while reset is asserted.
  always_comb begin
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    aluCtrl  = 3'b000;
    memRd    = 1'b0;
    memWr    = 1'b0;
    hiSel    = 2'b00;
    loSel    = 2'b00;
    hiWr     = 1'b0;
    loWr     = 1'b0;
    maluOp   = 1'b0;
    regDst   = 1'b0;
    regWr    = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    jalr     = 1'b0;
    memtoReg = 3'b000;
    if (rst) begin
      case (opcode)
        OP_ADD:  begin aluCtrl = 3'b000; regDst = 1'b1; regWr = 1'b1; end
        OP_SUB:  begin aluCtrl = 3'b001; regDst = 1'b1; regWr = 1'b1; end
        OP_AND:  begin aluCtrl = 3'b010; regDst = 1'b1; regWr = 1'b1; end
        OP_OR:   begin aluCtrl = 3'b011; regDst = 1'b1; regWr = 1'b1; end
        OP_SLT:  begin aluCtrl = 3'b110; regDst = 1'b1; regWr = 1'b1; end
        OP_SLL:  begin aluCtrl = 3'b100; aluSrcA = 1'b1; regDst = 1'b1; regWr = 1'b1; end
        OP_SRL:  begin aluCtrl = 3'b101; aluSrcA = 1'b1; regDst = 1'b1; regWr = 1'b1; end
        OP_ADDI: begin aluCtrl = 3'b000; aluSrcB = 2'b01; regWr = 1'b1; end
        OP_SLTI: begin aluCtrl = 3'b110; aluSrcB = 2'b01; regWr = 1'b1; end
        OP_ANDI: begin aluCtrl = 3'b010; aluSrcB = 2'b10; regWr = 1'b1; end
        OP_ORI:  begin aluCtrl = 3'b011; aluSrcB = 2'b10; regWr = 1'b1; end
        OP_LUI:  begin memtoReg = 3'b100; regWr = 1'b1; end
        OP_LW:   begin aluSrcB = 2'b01; memRd = 1'b1; memtoReg = 3'b001; regWr = 1'b1; end
        OP_SW:   begin aluSrcB = 2'b01; memWr = 1'b1; end
        OP_MULT: begin aluCtrl = 3'b111; hiWr = 1'b1; loWr = 1'b1; end
        OP_MADD, OP_MSUB: begin
          aluCtrl = 3'b111;
          hiSel   = 2'b10;
          loSel   = 2'b10;
          hiWr    = 1'b1;
          loWr    = 1'b1;
          maluOp  = (opcode == OP_MSUB);
        end
        OP_MFHI: begin memtoReg = 3'b010; regDst = 1'b1; regWr = 1'b1; end
        OP_MFLO: begin memtoReg = 3'b011; regDst = 1'b1; regWr = 1'b1; end
        OP_MTHI: begin hiSel = 2'b01; hiWr = 1'b1; end
        OP_MTLO: begin loSel = 2'b01; loWr = 1'b1; end
        OP_BEQ:  begin aluCtrl = 3'b001; branch = 1'b1; end
        OP_J:    begin jump = 1'b1; end
        OP_JAL:  begin jump = 1'b1; memtoReg = 3'b101; regWr = 1'b1; end
        OP_JALR: begin jalr = 1'b1; memtoReg = 3'b101; regDst = 1'b1; regWr = 1'b1; end
        default: ;
      endcase
    end
  end

  logic [DW-1:0]   src1;
  logic [DW-1:0]   src2;
  logic [2*DW-1:0] prod;

  // Operand muxes
  always_comb begin
    src1 = aluSrcA ? {27'b0, shamt} : rs_data;
    case (aluSrcB)
      2'b00:   src2 = rt_data;
      2'b01:   src2 = {{16{imm[15]}}, imm};
      2'b10:   src2 = {16'b0, imm};
      default: src2 = '0;
    endcase
  end

  // Sign-extended operands make the low 64 bits of the product the signed product.
  assign prod = {{DW{src1[DW-1]}}, src1} * {{DW{src2[DW-1]}}, src2};

  always_comb begin
    resultA = '0;
    resultB = '0;
    case (aluCtrl)
      3'b000: resultA = src1 + src2;
      3'b001: resultA = src1 - src2;
      3'b010: resultA = src1 & src2;
      3'b011: resultA = src1 | src2;
      3'b100: resultA = src2 << src1[4:0];
      3'b101: resultA = src2 >> src1[4:0];
      3'b110: resultA = {31'b0, ($signed(src1) < $signed(src2))};
      default: begin
        resultA = prod[2*DW-1:DW];
        resultB = prod[DW-1:0];
      end
    endcase
  end

  assign zeroFlag = (resultA == '0) && (resultB == '0);

  logic [DW-1:0] mem [MEM_WORDS];
  logic [AW-1:0] addr;

  // Word address; byte offset and high bits ignored so addresses wrap.
  assign addr        = resultA[AW+1:2];
  assign memReadData = mem[addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (memWr) begin
      mem[addr] <= rt_data;
    end
  end

endmodule

// File: tb/tb_mips_exec_core.sv
// Self-checking bench for mips_exec_core: reset, decode sweep, ALU results,
// memory store/load with aliasing and reset priority, back-to-back stores.
module tb_mips_exec_core;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [2:0]  aluCtrl;
  logic        memRd;
  logic        memWr;
  logic [1:0]  hiSel;
  logic [1:0]  loSel;
  logic        hiWr;
  logic        loWr;
  logic        maluOp;
  logic        regDst;
  logic        regWr;
  logic        jump;
  logic        branch;
  logic        jalr;
  logic [2:0]  memtoReg;
  logic [31:0] resultA;
  logic [31:0] resultB;
  logic        zeroFlag;
  logic [31:0] memReadData;

  int total;
  int bad;

  logic [31:0] model [256];
  logic [31:0] rd_q [$];
  logic [22:0] ctrl_q [$];
  logic [64:0] alu_q [$];

  mips_exec_core #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rs_data(rs_data), .rt_data(rt_data),
    .shamt(shamt), .imm(imm), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtrl(aluCtrl),
    .memRd(memRd), .memWr(memWr), .hiSel(hiSel), .loSel(loSel), .hiWr(hiWr),
    .loWr(loWr), .maluOp(maluOp), .regDst(regDst), .regWr(regWr), .jump(jump),
    .branch(branch), .jalr(jalr), .memtoReg(memtoReg), .resultA(resultA),
    .resultB(resultB), .zeroFlag(zeroFlag), .memReadData(memReadData)
  );

  logic [22:0] ctrl_vec;
  assign ctrl_vec = {aluSrcA, aluSrcB, aluCtrl, memRd, memWr, hiSel, loSel, hiWr, loWr,
                     maluOp, regDst, regWr, jump, branch, jalr, memtoReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table, field by field from the opcode list.
  function automatic logic [22:0] exp_ctrl(input logic [5:0] op);
    logic a; logic [1:0] b; logic [2:0] c; logic mr, mw; logic [1:0] hs, ls;
    logic hw, lw, mo, rd, rw, j, br, jr; logic [2:0] m2r;
    a = 0; b = 0; c = 0; mr = 0; mw = 0; hs = 0; ls = 0; hw = 0; lw = 0;
    mo = 0; rd = 0; rw = 0; j = 0; br = 0; jr = 0; m2r = 0;
    case (op)
      6'd1:  begin c = 3'd0; rd = 1; rw = 1; end
      6'd2:  begin c = 3'd1; rd = 1; rw = 1; end
      6'd3:  begin c = 3'd2; rd = 1; rw = 1; end
      6'd4:  begin c = 3'd3; rd = 1; rw = 1; end
      6'd5:  begin c = 3'd6; rd = 1; rw = 1; end
      6'd6:  begin c = 3'd4; a = 1; rd = 1; rw = 1; end
      6'd7:  begin c = 3'd5; a = 1; rd = 1; rw = 1; end
      6'd8:  begin c = 3'd0; b = 2'd1; rw = 1; end
      6'd11: begin c = 3'd6; b = 2'd1; rw = 1; end
      6'd9:  begin c = 3'd2; b = 2'd2; rw = 1; end
      6'd10: begin c = 3'd3; b = 2'd2; rw = 1; end
      6'd12: begin m2r = 3'd4; rw = 1; end
      6'd16: begin b = 2'd1; mr = 1; m2r = 3'd1; rw = 1; end
      6'd17: begin b = 2'd1; mw = 1; end
      6'd24: begin c = 3'd7; hw = 1; lw = 1; end
      6'd25: begin c = 3'd7; hs = 2'd2; ls = 2'd2; hw = 1; lw = 1; end
      6'd26: begin c = 3'd7; hs = 2'd2; ls = 2'd2; hw = 1; lw = 1; mo = 1; end
      6'd27: begin m2r = 3'd2; rd = 1; rw = 1; end
      6'd28: begin m2r = 3'd3; rd = 1; rw = 1; end
      6'd29: begin hs = 2'd1; hw = 1; end
      6'd30: begin ls = 2'd1; lw = 1; end
      6'd32: begin c = 3'd1; br = 1; end
      6'd33: begin j = 1; end
      6'd34: begin j = 1; m2r = 3'd5; rw = 1; end
      6'd35: begin jr = 1; m2r = 3'd5; rd = 1; rw = 1; end
      default: ;
    endcase
    return {a, b, c, mr, mw, hs, ls, hw, lw, mo, rd, rw, j, br, jr, m2r};
  endfunction

  task automatic test_reset();
    logic [31:0] addrs [3];
    logic [31:0] exp;
    logic [22:0] ec;
    addrs = '{32'd0, 32'd4, 32'd1020};
    rst = 1'b0; opcode = 6'b010001; rs_data = 32'd8; rt_data = 32'hDEADBEEF;
    shamt = 5'd0; imm = 16'd4;
    ctrl_q.push_back(23'd0);
    #2;
    ec = ctrl_q.pop_front();
    total++;
    if (ctrl_vec !== ec) begin
      bad++;
      $display("FAIL reset_ctrl_gate: got %h expected %h", ctrl_vec, ec);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'b010000; rs_data = addrs[i]; rt_data = 32'd0; imm = 16'd0;
      rd_q.push_back(model[(addrs[i] >> 2) & 32'd255]);
      #2;
      exp = rd_q.pop_front();
      total++;
      if (memReadData !== exp) begin
        bad++;
        $display("FAIL reset_mem_%0d: got %h expected %h", addrs[i], memReadData, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_decode();
    logic [22:0] ec;
    for (int op = 0; op < 64; op++) begin
      opcode = 6'(op); rs_data = 32'd0; rt_data = 32'd0; imm = 16'd0; shamt = 5'd0;
      ctrl_q.push_back(exp_ctrl(6'(op)));
      #2;
      ec = ctrl_q.pop_front();
      total++;
      if (ctrl_vec !== ec) begin
        bad++;
        $display("FAIL decode_op%0d: got %h expected %h", op, ctrl_vec, ec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu();
    logic [5:0]  ops [16];
    logic [31:0] rss [16];
    logic [31:0] rts [16];
    logic [4:0]  shs [16];
    logic [15:0] ims [16];
    logic [31:0] ea  [16];
    logic [31:0] eb  [16];
    logic [64:0] e;
    ops = '{6'h08, 6'h02, 6'h06, 6'h05, 6'h18, 6'h01, 6'h03, 6'h04,
            6'h07, 6'h09, 6'h0A, 6'h0B, 6'h05, 6'h19, 6'h20, 6'h1A};
    rss = '{32'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0,
            32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 32'h10000, 32'd3, 32'h80000000};
    rts = '{32'd0, 32'd7, 32'hF, 32'd1, 32'd3, 32'd2, 32'hFF00FF00, 32'h0F,
            32'h80000000, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h10000, 32'd3, 32'h80000000};
    shs = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
            5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    ims = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
            16'd0, 16'h8001, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0};
    ea  = '{32'd4, 32'd0, 32'hF0, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hF000F000, 32'hFF,
            32'h08000000, 32'h8001, 32'h8000, 32'd0, 32'd0, 32'd1, 32'd0, 32'h40000000};
    eb  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFA, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 16; i++) begin
      opcode = ops[i]; rs_data = rss[i]; rt_data = rts[i]; shamt = shs[i]; imm = ims[i];
      alu_q.push_back({ea[i], eb[i], (ea[i] == 32'd0) && (eb[i] == 32'd0)});
      #2;
      e = alu_q.pop_front();
      total++;
      if (resultA !== e[64:33]) begin
        bad++;
        $display("FAIL alu%0d_resultA: got %h expected %h", i, resultA, e[64:33]);
      end
      total++;
      if (resultB !== e[32:1]) begin
        bad++;
        $display("FAIL alu%0d_resultB: got %h expected %h", i, resultB, e[32:1]);
      end
      total++;
      if (zeroFlag !== e[0]) begin
        bad++;
        $display("FAIL alu%0d_zeroFlag: got %b expected %b", i, zeroFlag, e[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem();
    logic [31:0] exp;
    logic [22:0] ec;
    // Store; a read in the same cycle still sees the old word.
    opcode = 6'b010001; rs_data = 32'd8; imm = 16'd4; rt_data = 32'hDEADBEEF; shamt = 5'd0;
    rd_q.push_back(model[3]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL mem_read_during_write: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
    model[3] = 32'hDEADBEEF;
    opcode = 6'b010000; rs_data = 32'd8; imm = 16'd4; rt_data = 32'd0;
    rd_q.push_back(model[3]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL mem_lw_after_sw: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
    rs_data = 32'd1036; imm = 16'd0;
    rd_q.push_back(model[3]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL mem_alias_1036: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
    rs_data = 32'd16; imm = 16'hFFFC;
    rd_q.push_back(model[3]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL mem_negative_offset: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
    // Store under reset: write suppressed, reset clears the word.
    rst = 1'b0; opcode = 6'b010001; rs_data = 32'd8; imm = 16'd4; rt_data = 32'h12345678;
    ctrl_q.push_back(23'd0);
    #2;
    ec = ctrl_q.pop_front();
    total++;
    if (ctrl_vec !== ec) begin
      bad++;
      $display("FAIL mem_sw_reset_ctrl: got %h expected %h", ctrl_vec, ec);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    rst = 1'b1; opcode = 6'b010000; rt_data = 32'd0;
    rd_q.push_back(model[3]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL mem_reset_priority: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    logic [31:0] d;
    logic [31:0] exp;
    addrs = '{32'd0, 32'd4, 32'd1020, 32'd1032, 32'd40, 32'd44, 32'd48, 32'd52};
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      opcode = 6'b010001; rs_data = addrs[i]; imm = 16'd0; rt_data = d; shamt = 5'd0;
      @(negedge clk);
      model[(addrs[i] >> 2) & 32'd255] = d;
    end
    for (int i = 0; i < 8; i++) begin
      opcode = 6'b010000; rs_data = addrs[i]; imm = 16'd0; rt_data = 32'd0;
      rd_q.push_back(model[(addrs[i] >> 2) & 32'd255]);
      #2;
      exp = rd_q.pop_front();
      total++;
      if (memReadData !== exp) begin
        bad++;
        $display("FAIL b2b_read_%0d: got %h expected %h", addrs[i], memReadData, exp);
      end
      @(negedge clk);
    end
    // Word 2 was written via alias 1032; word 0 must still hold its own data.
    opcode = 6'b010000; rs_data = 32'd1024; imm = 16'd0;
    rd_q.push_back(model[0]);
    #2;
    exp = rd_q.pop_front();
    total++;
    if (memReadData !== exp) begin
      bad++;
      $display("FAIL b2b_wrap_1024: got %h expected %h", memReadData, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_decode();
    test_alu();
    test_mem();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_core.md
# mips_exec_core

Execute-stage core of the single-cycle MIPS-style processor. It combines three functions: the opcode-only instruction decoder (control unit), the two-result ALU with its operand muxes, and a synchronous data memory. The top-level datapath supplies the register file, Hi/Lo, the 64-bit accumulate adder, PC logic and write-back muxing, and consumes the control signals and results produced here.

## Interface
- Parameters: `MEM_WORDS`, default 256. Number of 32-bit data-memory words; must be a power of 2.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous active-low reset.
- `opcode` input 6: instr[31:26].
- `rs_data` input 32: Reg[rs].
- `rt_data` input 32: Reg[rt]. It is ALU src2 when `aluSrcB`=00, and it is the store data.
- `shamt` input 5: instr[10:6].
- `imm` input 16: instr[15:0].
- `aluSrcA` output 1: src1 select; 0 selects `rs_data`, 1 selects zero-extended shamt.
- `aluSrcB` output 2: src2 select; 00 selects `rt_data`, 01 sign-extended imm, 10 zero-extended imm, 11 zero.
- `aluCtrl` output 3: ALU operation.
- `memRd`, `memWr` output 1 each: memory read strobe and memory write enable.
- `hiSel`, `loSel` output 2 each: Hi/Lo source; 00 selects ALU result, 01 `rs_data`, 10 64-bit adder.
- `hiWr`, `loWr`, `maluOp`, `regDst`, `regWr`, `jump`, `branch`, `jalr` output 1 each.
- `memtoReg` output 3: write-back source; 000 ALU, 001 memory, 010 Hi, 011 Lo, 100 imm<<16, 101 PC+4.
- `resultA` output 32: primary ALU result, or the product high word for MUL.
- `resultB` output 32: product low word for MUL; 0 for every other operation.
- `zeroFlag` output 1: high when `resultA` and `resultB` are both 0.
- `memReadData` output 32: data-memory read word.

## Operation
- Decode is combinational. Every control output is 0 unless listed for the opcode.
- 000000 HALT: all 0.
- 000001 ADD, 000010 SUB, 000011 AND, 000100 OR, 000101 SLT: `aluCtrl` = 000, 001, 010, 011, 110 respectively; `regDst`=1, `regWr`=1.
- 000110 SLL, 000111 SRL: `aluCtrl` = 100, 101; `aluSrcA`=1, `regDst`=1, `regWr`=1.
- 001000 ADDI, 001011 SLTI: `aluCtrl` = 000, 110; `aluSrcB`=01, `regWr`=1.
- 001001 ANDI, 001010 ORI: `aluCtrl` = 010, 011; `aluSrcB`=10, `regWr`=1.
- 001100 LUI: `memtoReg`=100, `regWr`=1.
- 010000 LW: `aluSrcB`=01, `memRd`=1, `memtoReg`=001, `regWr`=1.
- 010001 SW: `aluSrcB`=01, `memWr`=1.
- 011000 MULT: `aluCtrl`=111, `hiWr`=1, `loWr`=1.
- 011001 MADD, 011010 MSUB: `aluCtrl`=111; `hiSel`=`loSel`=10; `hiWr`=1, `loWr`=1; `maluOp`=0 for MADD, 1 for MSUB.
- 011011 MFHI, 011100 MFLO: `memtoReg` = 010, 011; `regDst`=1, `regWr`=1.
- 011101 MTHI: `hiSel`=01, `hiWr`=1. 011110 MTLO: `loSel`=01, `loWr`=1.
- 100000 BEQ: `aluCtrl`=001, `branch`=1.
- 100001 J: `jump`=1.
- 100010 JAL: `jump`=1, `memtoReg`=101, `regWr`=1.
- 100011 JALR: `jalr`=1, `memtoReg`=101, `regDst`=1, `regWr`=1.
- Any other opcode: all 0 (NOP).
- ALU operations, with src1/src2 taken after the operand muxes:
  - ADD and SUB: wrap mod 2^32.
  - AND, OR: bitwise.
  - SLL: src2 << src1[4:0]. SRL: logical src2 >> src1[4:0].
  - SLT: signed compare; result is 1 or 0.
  - MUL: signed 32x32 → 64; `resultA`=[63:32], `resultB`=[31:0].
- Memory addressing: word address = `resultA`[log2(MEM_WORDS)+1:2]; upper bits and bits [1:0] are ignored, so addresses wrap.
- Memory read: combinational; `memReadData` always shows the addressed word, regardless of `memRd`.

## Timing
- ALU and decode: zero latency; purely combinational from the inputs.
- Store: on a rising `clk` edge with `rst`=1 and `memWr`=1, mem[addr] ← `rt_data`.
- Read after store: new data is visible on `memReadData` after that edge. A read of the same address in the write cycle returns the old data.
- Reset: on a rising edge with `rst`=0, every memory word clears to 0.
- Control gating: while `rst`=0, all control outputs are forced to 0, and no write occurs even if the opcode is SW.
- Reset priority: reset asserted during a store cycle wins; the word is 0 afterwards.
- Only memory holds state; there is no other state.

## Test plan
- Reset: hold `rst`=0 for one edge, then read addresses 0, 4 and 1020 → `memReadData`=0 each; all control outputs are 0 while `rst`=0.
- Decode sweep: apply each listed opcode → exact control vector per table; opcode 111111 → all 0.
- ADDI: `rs_data`=5, imm=0xFFFF → `resultA`=4; then SUB with `rs_data`=`rt_data`=7 → `resultA`=0, `zeroFlag`=1.
- SLL: shamt=4, `rt_data`=0x0000_000F → `resultA`=0xF0. SLT: `rs_data`=0xFFFF_FFFF, `rt_data`=1 → `resultA`=1.
- MULT: `rs_data`=0xFFFF_FFFE (-2), `rt_data`=3 → `resultA`=0xFFFF_FFFF, `resultB`=0xFFFF_FFFA, `zeroFlag`=0.
- SW, then LW: SW with `rs_data`=8, imm=4, `rt_data`=0xDEADBEEF, one edge; then LW with the same address → `memReadData`=0xDEADBEEF. Address 1036 aliases to 12 → same word. SW with `rst`=0 → memory unchanged.
